ifmap_pingpong_bank: RTL and testbench
======================================

// Module: ifmap_pingpong_bank
// PURPOSE
// - Double-buffered input feature-map store for the conv engine. Generalises the fixed 4-phase SRAM_I array
//   (2x2 h/w interleave) to N_PHASE phases.
// - A streaming loader fills the shadow buffer with the next channel group while conv reads the active one;
//   conv requests a swap at group end. No timed reloads.
// PARAMETERS
// - WORD_W  128   bits per SRAM word (16 px x 8 b)
// - DEPTH   3136  words per phase memory (112*112/4)
// - N_PHASE 4     interleaved phase memories per buffer (h,w parity)
// - ADDR_W  $clog2(DEPTH)  derived; do not override
// PORTS
// - clk       in   1                clock, all logic on posedge
// - rst       in   1                synchronous, active-high reset
// - ld_valid  in   1                load word valid
// - ld_ready  out  1                loader may transfer (shadow buffer FILLING)
// - ld_data   in   WORD_W           load word; order phase-major, addr 0..DEPTH-1 within each phase
// - rd_en     in   1                read strobe, all phases
// - rd_addr   in   N_PHASE*ADDR_W   per-phase read address, phase p at [p*ADDR_W +: ADDR_W]
// - rd_data   out  N_PHASE*WORD_W   per-phase read data, same packing
// - swap_req  in   1                pulse: conv finished current group
// - swap_ack  out  1                1-cycle pulse when the new buffer becomes active
// - act_valid out  1                active buffer holds a complete group
// - shd_full  out  1                shadow buffer complete, waiting for swap
// BEHAVIOUR
// - Reset: act_sel=0; both buffers EMPTY; ld_cnt/ph_cnt=0; swap_pend=0.
//   Outputs after reset: ld_ready=1, rd_data=0, swap_ack=0, act_valid=0, shd_full=0.
//   Memory contents are not cleared. A reset mid-fill or mid-swap abandons all partial state.
// - Per-buffer state: EMPTY -> FILLING -> FULL -> ACTIVE -> EMPTY.
// - Fill target = !act_sel.
//   - Before the first group: target = buffer 0. It moves to ACTIVE (act_sel stays 0) on the edge after its last word.
// - Load:
//   - ld_ready = target is EMPTY or FILLING.
//   - Transfer on ld_valid && ld_ready: write mem[target][ph_cnt][ld_cnt], then ld_cnt++.
//   - At ld_cnt==DEPTH-1: ld_cnt wraps to 0 and ph_cnt++.
//   - Write at (ph_cnt==N_PHASE-1, ld_cnt==DEPTH-1): target becomes FULL and ld_ready drops the next cycle.
// - Read: registered, latency 1. rd_data = mem[act_sel][p][rd_addr_p] one cycle after rd_en.
//   - rd_data holds its value when rd_en=0.
//   - Reads with act_valid=0 return undefined data (the bench must not check them).
// - Swap:
//   - swap_req sets swap_pend. A swap executes on the first edge with swap_pend && shadow FULL.
//   - Execute: act_sel flips, the old active buffer becomes EMPTY and is the new fill target, swap_pend clears.
//   - swap_ack=1 for the cycle after execution.
//   - A swap_req while swap_pend=1 is ignored (no queueing).
//   - swap_req with no buffer ACTIVE is ignored.
// - Simultaneous events:
//   - swap_req on the same edge as the last load word: FULL takes effect at that edge. The swap executes one edge later.
//   - rd_en on the swap edge reads the old act_sel.
// - Status decodes (registered state, combinational decode):
//   - act_valid = any buffer ACTIVE.
//   - shd_full = target FULL.
// - Address bounds: rd_addr >= DEPTH is undefined. SVA flags it in simulation.
// STRUCTURE
// - Package conv_pkg:
//   - typedef buf_state_e {EMPTY, FILLING, FULL, ACTIVE}
//   - constants IFMAP_WORD_W=128, IFMAP_DEPTH=3136, IFMAP_N_PHASE=4
// - Sub-module bank_sram:
//   - 1R1W synchronous, DEPTH x WORD_W, 1-cycle read, `memory` array name kept for $readmemb backdoor.
//   - Instantiated 2*N_PHASE times in a generate loop.
// - Top level holds the fill counters, the buffer state registers, the swap FSM and the read mux.
// TESTING (WORD_W=16, DEPTH=8, N_PHASE=4 unless noted)
// - Reset then stream 32 words of value 0x0100+i.
//   -> act_valid=1 on the cycle after word 31; ld_ready stays 1.
//   -> Read addr 3 on all phases: {0x0103,0x010B,0x0113,0x011B}.
// - Fill shadow (0x0200+i), then pulse swap_req.
//   -> swap_ack one cycle after the swap edge; addr 0 reads {0x0200,0x0208,0x0210,0x0218}.
//   -> ld_ready=1 again for the freed buffer.
// - swap_req after shadow has 10/32 words, then stream the rest.
//   -> swap executes on the edge after word 31; exactly one swap_ack; repeat swap_req while pending is ignored.
// - swap_req on the same cycle as last load word.
//   -> swap edge one cycle later.
//   -> rd_en held across the swap returns old data on the swap edge, new data after.
// - Assert rst mid-fill (word 13), then refill.
//   -> outputs at reset values next cycle; the new fill starts at phase 0 addr 0 of buffer 0.
// - Default parameters: backdoor-load 4 phases from input_cgroup files, stream cgroup1 via loader, swap.
//   -> rd_data matches the file words at addrs 0, 1567, 3135.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and sizing constants for the conv engine feature-map stores
package conv_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2,
      ACTIVE  = 2'd3
   } buf_state_e;

   localparam int IFMAP_WORD_W  = 128;
   localparam int IFMAP_DEPTH   = 3136;
   localparam int IFMAP_N_PHASE = 4;

endpackage

// File: rtl/bank_sram.sv
// rtl/bank_sram.sv - 1R1W synchronous SRAM, one-cycle registered read
module bank_sram #(
   parameter  int WORD_W = 128,
   parameter  int DEPTH  = 3136,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] memory [DEPTH];

   always_ff @(posedge clk) begin
      if (we) memory[waddr] <= wdata;
      if (re) rdata <= memory[raddr];
   end

endmodule

// File: rtl/ifmap_pingpong_bank.sv
// rtl/ifmap_pingpong_bank.sv - double-buffered N-phase input feature-map store with streaming loader
module ifmap_pingpong_bank
   import conv_pkg::*;
#(
   parameter  int WORD_W  = IFMAP_WORD_W,
   parameter  int DEPTH   = IFMAP_DEPTH,
   parameter  int N_PHASE = IFMAP_N_PHASE,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ld_valid,
   output logic                      ld_ready,
   input  logic [WORD_W-1:0]         ld_data,
   input  logic                      rd_en,
   input  logic [N_PHASE*ADDR_W-1:0] rd_addr,
   output logic [N_PHASE*WORD_W-1:0] rd_data,
   input  logic                      swap_req,
   output logic                      swap_ack,
   output logic                      act_valid,
   output logic                      shd_full
);

   localparam int PH_W = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;

   buf_state_e        buf_st [2];
   logic              act_sel;
   logic              swap_pend;
   logic              swap_ack_q;
   logic              rd_vld_q;
   logic              rd_sel_q;
   logic [ADDR_W-1:0] ld_cnt;
   logic [PH_W-1:0]   ph_cnt;

   logic any_active;
   logic tgt;
   logic xfer;
   logic last_word;
   logic swap_go;

   logic [WORD_W-1:0] bank_q [2][N_PHASE];

   // Before the first group completes nothing is active and act_sel=0, so the loader fills buffer 0.
   always_comb begin
      any_active = (buf_st[0] == ACTIVE) || (buf_st[1] == ACTIVE);
      tgt        = any_active ? ~act_sel : act_sel;
      ld_ready   = (buf_st[tgt] == EMPTY) || (buf_st[tgt] == FILLING);
      xfer       = ld_valid && ld_ready;
      last_word  = (ph_cnt == PH_W'(N_PHASE - 1)) && (ld_cnt == ADDR_W'(DEPTH - 1));
      swap_go    = swap_pend && (buf_st[tgt] == FULL);
      act_valid  = any_active;
      shd_full   = (buf_st[tgt] == FULL);
      swap_ack   = swap_ack_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_st[0]  <= EMPTY;
         buf_st[1]  <= EMPTY;
         act_sel    <= 1'b0;
         swap_pend  <= 1'b0;
         swap_ack_q <= 1'b0;
         rd_vld_q   <= 1'b0;
         rd_sel_q   <= 1'b0;
         ld_cnt     <= '0;
         ph_cnt     <= '0;
      end else begin
         swap_ack_q <= swap_go;

         // swap_go and xfer are exclusive: a FULL target deasserts ld_ready.
         if (swap_go) begin
            act_sel         <= ~act_sel;
            buf_st[act_sel] <= EMPTY;
            buf_st[tgt]     <= ACTIVE;
            swap_pend       <= 1'b0;
         end else if (swap_req && any_active) begin
            swap_pend <= 1'b1;
         end

         if (xfer) begin
            if (last_word) begin
               ld_cnt      <= '0;
               ph_cnt      <= '0;
               buf_st[tgt] <= any_active ? FULL : ACTIVE;
            end else begin
               buf_st[tgt] <= FILLING;
               if (ld_cnt == ADDR_W'(DEPTH - 1)) begin
                  ld_cnt <= '0;
                  ph_cnt <= ph_cnt + 1'b1;
               end else begin
                  ld_cnt <= ld_cnt + 1'b1;
               end
            end
         end

         // Select is captured with the read so a read on the swap edge returns the old buffer.
         if (rd_en) begin
            rd_vld_q <= 1'b1;
            rd_sel_q <= act_sel;
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_buf
      for (genvar p = 0; p < N_PHASE; p++) begin : g_ph
         bank_sram #(
            .WORD_W (WORD_W),
            .DEPTH  (DEPTH)
         ) u_sram (
            .clk   (clk),
            .we    (xfer && (tgt == 1'(b)) && (ph_cnt == PH_W'(p))),
            .waddr (ld_cnt),
            .wdata (ld_data),
            .re    (rd_en),
            .raddr (rd_addr[p*ADDR_W +: ADDR_W]),
            .rdata (bank_q[b][p])
         );
      end
   end

   for (genvar p = 0; p < N_PHASE; p++) begin : g_rd
      assign rd_data[p*WORD_W +: WORD_W] = rd_vld_q ? bank_q[rd_sel_q][p] : '0;

      a_rd_addr_range : assert property (@(posedge clk) disable iff (rst)
         rd_en |-> (int'(rd_addr[p*ADDR_W +: ADDR_W]) < DEPTH));
   end

endmodule

// File: tb/tb_ifmap_pingpong_bank.sv
// tb/tb_ifmap_pingpong_bank.sv - directed self-checking bench for ifmap_pingpong_bank
module tb_ifmap_pingpong_bank;

   localparam int WORD_W  = 16;
   localparam int DEPTH   = 8;
   localparam int N_PHASE = 4;
   localparam int ADDR_W  = 3;
   localparam int NWORDS  = DEPTH * N_PHASE;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic                      ld_valid = 1'b0;
   logic                      ld_ready;
   logic [WORD_W-1:0]         ld_data = '0;
   logic                      rd_en = 1'b0;
   logic [N_PHASE*ADDR_W-1:0] rd_addr = '0;
   logic [N_PHASE*WORD_W-1:0] rd_data;
   logic                      swap_req = 1'b0;
   logic                      swap_ack;
   logic                      act_valid;
   logic                      shd_full;

   int checks = 0;
   int errors = 0;

   ifmap_pingpong_bank #(
      .WORD_W  (WORD_W),
      .DEPTH   (DEPTH),
      .N_PHASE (N_PHASE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_data   (ld_data),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .swap_req  (swap_req),
      .swap_ack  (swap_ack),
      .act_valid (act_valid),
      .shd_full  (shd_full)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Group words are base+i, phase-major, so phase p addr a holds base + p*DEPTH + a.
   function automatic logic [N_PHASE*WORD_W-1:0] exp_rd(input int base, input int a);
      logic [N_PHASE*WORD_W-1:0] v;
      for (int p = 0; p < N_PHASE; p++) v[p*WORD_W +: WORD_W] = WORD_W'(base + p*DEPTH + a);
      return v;
   endfunction

   task automatic stream(input int base, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         ld_valid = 1'b1;
         ld_data  = WORD_W'(base + i);
         step();
      end
      ld_valid = 1'b0;
   endtask

   task automatic read_all(input int a);
      rd_en   = 1'b1;
      rd_addr = {N_PHASE{ADDR_W'(a)}};
      step();
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      checks++;
      if ({ld_ready, swap_ack, act_valid, shd_full} !== 4'b1000 || rd_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy/ack/act/full=%b rd_data=%h, want 1000 and 0",
                  {ld_ready, swap_ack, act_valid, shd_full}, rd_data);
      end
   endtask

   task automatic test_first_fill();
      stream(16'h0100, 0, NWORDS - 2);
      checks++;
      if (act_valid !== 1'b0) begin
         errors++;
         $display("FAIL first_fill_early_act: got act_valid=%b, want 0", act_valid);
      end
      stream(16'h0100, NWORDS - 1, NWORDS - 1);
      checks++;
      if (act_valid !== 1'b1 || ld_ready !== 1'b1) begin
         errors++;
         $display("FAIL first_fill_done: got act_valid=%b ld_ready=%b, want 1 1", act_valid, ld_ready);
      end
      read_all(3);
      checks++;
      if (rd_data !== exp_rd(16'h0100, 3)) begin
         errors++;
         $display("FAIL first_fill_read: got %h, want %h", rd_data, exp_rd(16'h0100, 3));
      end
      step();
      checks++;
      if (rd_data !== exp_rd(16'h0100, 3)) begin
         errors++;
         $display("FAIL read_hold: got %h, want %h", rd_data, exp_rd(16'h0100, 3));
      end
   endtask

   task automatic test_swap();
      stream(16'h0200, 0, NWORDS - 1);
      checks++;
      if (shd_full !== 1'b1 || ld_ready !== 1'b0) begin
         errors++;
         $display("FAIL shadow_full: got shd_full=%b ld_ready=%b, want 1 0", shd_full, ld_ready);
      end
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      checks++;
      if (swap_ack !== 1'b0) begin
         errors++;
         $display("FAIL swap_ack_early: got %b, want 0", swap_ack);
      end
      step();
      checks++;
      if ({swap_ack, ld_ready, act_valid, shd_full} !== 4'b1110) begin
         errors++;
         $display("FAIL swap_exec: got ack/rdy/act/full=%b, want 1110", {swap_ack, ld_ready, act_valid, shd_full});
      end
      read_all(0);
      checks++;
      if (swap_ack !== 1'b0 || rd_data !== exp_rd(16'h0200, 0)) begin
         errors++;
         $display("FAIL swap_read: got ack=%b data=%h, want 0 %h", swap_ack, rd_data, exp_rd(16'h0200, 0));
      end
   endtask

   task automatic test_pending_swap();
      int acks;
      acks = 0;
      stream(16'h0300, 0, 9);
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      step();
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      for (int i = 10; i < NWORDS; i++) begin
         ld_valid = 1'b1;
         ld_data  = WORD_W'(16'h0300 + i);
         step();
         if (swap_ack === 1'b1) acks++;
      end
      ld_valid = 1'b0;
      checks++;
      if (shd_full !== 1'b1 || acks != 0) begin
         errors++;
         $display("FAIL pend_before_last: got shd_full=%b acks=%0d, want 1 0", shd_full, acks);
      end
      step();
      checks++;
      if (swap_ack !== 1'b1) begin
         errors++;
         $display("FAIL pend_swap_edge: got swap_ack=%b, want 1", swap_ack);
      end
      for (int i = 0; i < 4; i++) begin
         if (swap_ack === 1'b1) acks++;
         step();
      end
      checks++;
      if (acks != 1) begin
         errors++;
         $display("FAIL pend_single_ack: got %0d acks, want 1", acks);
      end
      read_all(5);
      checks++;
      if (rd_data !== exp_rd(16'h0300, 5)) begin
         errors++;
         $display("FAIL pend_read: got %h, want %h", rd_data, exp_rd(16'h0300, 5));
      end
   endtask

   task automatic test_same_cycle_swap();
      stream(16'h0400, 0, NWORDS - 2);
      ld_valid = 1'b1;
      ld_data  = WORD_W'(16'h0400 + NWORDS - 1);
      swap_req = 1'b1;
      step();
      ld_valid = 1'b0;
      swap_req = 1'b0;
      rd_en    = 1'b1;
      rd_addr  = {N_PHASE{ADDR_W'(2)}};
      checks++;
      if (swap_ack !== 1'b0 || shd_full !== 1'b1) begin
         errors++;
         $display("FAIL same_cycle_full: got ack=%b shd_full=%b, want 0 1", swap_ack, shd_full);
      end
      step();
      checks++;
      if (swap_ack !== 1'b1 || rd_data !== exp_rd(16'h0300, 2)) begin
         errors++;
         $display("FAIL same_cycle_old: got ack=%b data=%h, want 1 %h", swap_ack, rd_data, exp_rd(16'h0300, 2));
      end
      step();
      rd_en = 1'b0;
      checks++;
      if (rd_data !== exp_rd(16'h0400, 2)) begin
         errors++;
         $display("FAIL same_cycle_new: got %h, want %h", rd_data, exp_rd(16'h0400, 2));
      end
   endtask

   task automatic test_reset_mid_fill();
      int acks;
      acks = 0;
      stream(16'h0500, 0, 12);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({ld_ready, swap_ack, act_valid, shd_full} !== 4'b1000 || rd_data !== '0) begin
         errors++;
         $display("FAIL midfill_reset: got rdy/ack/act/full=%b rd_data=%h, want 1000 and 0",
                  {ld_ready, swap_ack, act_valid, shd_full}, rd_data);
      end
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      stream(16'h0600, 0, NWORDS - 1);
      checks++;
      if (act_valid !== 1'b1 || ld_ready !== 1'b1) begin
         errors++;
         $display("FAIL refill_done: got act_valid=%b ld_ready=%b, want 1 1", act_valid, ld_ready);
      end
      read_all(0);
      checks++;
      if (rd_data !== exp_rd(16'h0600, 0)) begin
         errors++;
         $display("FAIL refill_read0: got %h, want %h", rd_data, exp_rd(16'h0600, 0));
      end
      read_all(7);
      checks++;
      if (rd_data !== exp_rd(16'h0600, 7)) begin
         errors++;
         $display("FAIL refill_read7: got %h, want %h", rd_data, exp_rd(16'h0600, 7));
      end
      stream(16'h0700, 0, NWORDS - 1);
      for (int i = 0; i < 4; i++) begin
         if (swap_ack === 1'b1) acks++;
         step();
      end
      checks++;
      if (acks != 0 || shd_full !== 1'b1) begin
         errors++;
         $display("FAIL idle_swap_ignored: got acks=%0d shd_full=%b, want 0 1", acks, shd_full);
      end
   endtask

   initial begin
      test_reset();
      test_first_fill();
      test_swap();
      test_pending_swap();
      test_same_cycle_swap();
      test_reset_mid_fill();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
